wb_slave_mem: RTL and testbench

- Wishbone classic single-port slave that responds to the wb master's single and block cycles.
- Contains a small byte-lane-writable data memory, plus a parallel tag memory that stores TGD per word.
- Programmable wait states; issues ERR on bad addresses and RTY when the backing resource is busy.
- Sits directly downstream of the master on the shared bus, for bench and early integration.

---
 rtl/wb_slave_mem.sv | 163 ++++++++++++++++
 tb/tb_wb_slave_mem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave with a byte-lane data memory and a per-word tag memory.
// Programmable wait states; ERR on bad address, RTY while the backing store is busy.
module wb_slave_mem #(
  parameter int ADR_MSB     = 31,
  parameter int DATA_MSB    = 31,
  parameter int SEL_MSB     = 3,
  parameter int TAG_MSB     = 3,
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADR_MSB:0]  adr_i,
  input  logic [DATA_MSB:0] dat_i,
  input  logic [SEL_MSB:0]  sel_i,
  input  logic              we_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  input  logic [TAG_MSB:0]  tga_i,
  input  logic [TAG_MSB:0]  tgc_i,
  input  logic [TAG_MSB:0]  tgd_i,
  input  logic              busy_i,
  output logic [DATA_MSB:0] dat_o,
  output logic [TAG_MSB:0]  tgd_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              rty_o
);

  localparam int L     = $clog2(SEL_MSB + 1);
  localparam int WORDS = 1 << DEPTH_LOG2;

  // Address bits allowed to be set: the word index field only.
  localparam logic [ADR_MSB:0] OK_MASK =
    {{(ADR_MSB + 1 - DEPTH_LOG2){1'b0}},
     {DEPTH_LOG2{1'b1}}} << L;

  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_req;
  logic w_bad;
  logic w_ack_nxt;
  logic w_err_nxt;
  logic w_rty_nxt;
  logic w_unused;

  logic [DEPTH_LOG2-1:0] w_idx;

  logic [DATA_MSB:0] r_mem [WORDS];
  logic [TAG_MSB:0]  r_tag [WORDS];

  assign w_req    = cyc_i & stb_i;
  assign w_bad    = |(adr_i & ~OK_MASK);
  assign w_idx    = adr_i[DEPTH_LOG2+L-1:L];
  assign w_unused = ^{tga_i, tgc_i};

  // Next-state and next-termination decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rty_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_bad) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
          end else if (busy_i) begin
            w_state_nxt = S_RESP;
            w_rty_nxt   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = S_RESP;
            w_ack_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, wait counter and registered terminations.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rty_o   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      ack_o   <= w_ack_nxt;
      err_o   <= w_err_nxt;
      rty_o   <= w_rty_nxt;
    end
  end

  // Memory access on the edge that raises ack; reads load the output regs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_o <= '0;
      tgd_o <= '0;
      for (int w = 0; w < WORDS; w++) begin
        r_mem[w] <= '0;
        r_tag[w] <= '0;
      end
    end else if (w_ack_nxt) begin
      if (we_i) begin
        for (int i = 0; i <= SEL_MSB; i++) begin
          if (sel_i[i]) begin
            r_mem[w_idx][8*i +: 8] <= dat_i[8*i +: 8];
          end
        end
        if (|sel_i) begin
          r_tag[w_idx] <= tgd_i;
        end
      end else begin
        dat_o <= r_mem[w_idx];
        tgd_o <= r_tag[w_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Scoreboard bench for wb_slave_mem: two instances, one and three wait states.
// Drivers push expected terminations; a negedge monitor pops and compares.
module tb_wb_slave_mem;

  typedef struct {
    logic [2:0]  term;
    bit          rd;
    logic [31:0] dat;
    logic [3:0]  tgd;
    int          cyc;
  } exp_t;

  localparam logic [2:0] T_ACK = 3'b100;
  localparam logic [2:0] T_ERR = 3'b010;
  localparam logic [2:0] T_RTY = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] adr   [2];
  logic [31:0] dat   [2];
  logic [3:0]  sel   [2];
  logic        we    [2];
  logic        stb   [2];
  logic        cyc   [2];
  logic [3:0]  tgd   [2];
  logic        busy  [2];
  logic [31:0] dat_o [2];
  logic [3:0]  tgd_o [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic        rty_o [2];

  exp_t        q [2][$];
  logic [31:0] last_dat [2];
  logic [3:0]  last_tgd [2];
  exp_t        m_e;

  int cyc_cnt = 0;
  int n_chk   = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .clk_i (clk),      .rst_i (rst),
    .adr_i (adr[0]),   .dat_i (dat[0]),
    .sel_i (sel[0]),   .we_i  (we[0]),
    .stb_i (stb[0]),   .cyc_i (cyc[0]),
    .tga_i (4'h5),     .tgc_i (4'hA),
    .tgd_i (tgd[0]),   .busy_i(busy[0]),
    .dat_o (dat_o[0]), .tgd_o (tgd_o[0]),
    .ack_o (ack_o[0]), .err_o (err_o[0]),
    .rty_o (rty_o[0])
  );

  wb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .clk_i (clk),      .rst_i (rst),
    .adr_i (adr[1]),   .dat_i (dat[1]),
    .sel_i (sel[1]),   .we_i  (we[1]),
    .stb_i (stb[1]),   .cyc_i (cyc[1]),
    .tga_i (4'h3),     .tgc_i (4'hC),
    .tgd_i (tgd[1]),   .busy_i(busy[1]),
    .dat_o (dat_o[1]), .tgd_o (tgd_o[1]),
    .ack_o (ack_o[1]), .err_o (err_o[1]),
    .rty_o (rty_o[1])
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Monitor: every termination must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack_o[d] || err_o[d] || rty_o[d]) begin
        if (q[d].size() == 0) begin
          chk($sformatf("unexpected_term%0d", d),
              {ack_o[d], err_o[d], rty_o[d]}, 3'b000);
        end else begin
          m_e = q[d].pop_front();
          chk($sformatf("term_kind%0d", d),
              {ack_o[d], err_o[d], rty_o[d]}, m_e.term);
          chk($sformatf("term_cycle%0d", d), cyc_cnt, m_e.cyc);
          if (m_e.term == T_ACK && m_e.rd) begin
            last_dat[d] = m_e.dat;
            last_tgd[d] = m_e.tgd;
          end
          chk($sformatf("dat_o%0d", d), dat_o[d], last_dat[d]);
          chk($sformatf("tgd_o%0d", d), tgd_o[d], last_tgd[d]);
        end
      end
    end
  end

  task automatic idle_bus(input int d);
    adr[d] = '0; dat[d] = '0; sel[d] = '0; we[d] = 1'b0;
    stb[d] = 1'b0; cyc[d] = 1'b0; tgd[d] = '0; busy[d] = 1'b0;
  endtask

  // One complete master cycle with an expected termination.
  task automatic xfer(input int d, input bit w,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [3:0] tg,
                      input bit bz, input logic [2:0] et,
                      input logic [31:0] ed, input logic [3:0] etg,
                      input int hold);
    exp_t e;
    bit   seen;
    adr[d] = a; dat[d] = wd; sel[d] = s; we[d] = w;
    tgd[d] = tg; busy[d] = bz; cyc[d] = 1'b1; stb[d] = 1'b1;
    e.term = et; e.rd = !w; e.dat = ed; e.tgd = etg;
    e.cyc  = cyc_cnt + 1 + ((et == T_ACK) ? ws_of(d) : 0);
    q[d].push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = ack_o[d] | err_o[d] | rty_o[d];
    end
    if (!seen) chk($sformatf("timeout%0d", d), 0, 1);
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1;
    idle_bus(d);
    @(posedge clk);
    #1;
  endtask

  // Start a write and abandon it after two edges (drop or reset).
  task automatic abort_wr(input int d, input logic [31:0] a,
                          input logic [31:0] wd, input bit by_rst);
    adr[d] = a; dat[d] = wd; sel[d] = 4'hF; we[d] = 1'b1;
    tgd[d] = 4'hE; cyc[d] = 1'b1; stb[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (by_rst) begin
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst_dat%0d", k), dat_o[k], 32'h0);
        chk($sformatf("rst_tgd%0d", k), tgd_o[k], 4'h0);
        chk($sformatf("rst_term%0d", k),
            {ack_o[k], err_o[k], rty_o[k]}, 3'b000);
        last_dat[k] = '0;
        last_tgd[k] = '0;
      end
      idle_bus(d);
      #2 rst = 1'b0;
    end else begin
      idle_bus(d);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_bus(d);
      last_dat[d] = '0;
      last_tgd[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_dat%0d", d), dat_o[d], 32'h0);
      chk($sformatf("reset_tgd%0d", d), tgd_o[d], 4'h0);
      chk($sformatf("reset_term%0d", d),
          {ack_o[d], err_o[d], rty_o[d]}, 3'b000);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One wait state: full, partial and empty-select writes.
    xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, 4'h7, 0, T_ACK, 0, 0, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'hF, 4'h0, 0,
         T_ACK, 32'hDEADBEEF, 4'h7, 0);
    xfer(0, 1, 32'h08, 32'h00001234, 4'h3, 4'h2, 0, T_ACK, 0, 0, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 4'h0, 0,
         T_ACK, 32'hDEAD1234, 4'h2, 0);
    xfer(0, 1, 32'h08, 32'hFFFFFFFF, 4'h0, 4'h5, 0, T_ACK, 0, 0, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'hF, 4'h0, 0,
         T_ACK, 32'hDEAD1234, 4'h2, 0);

    // Bad addresses terminate with ERR and touch nothing.
    xfer(0, 1, 32'h42, 32'h0BADF00D, 4'hF, 4'h1, 0, T_ERR, 0, 0, 0);
    xfer(0, 0, 32'h40, 32'h0, 4'hF, 4'h0, 0, T_ERR, 0, 0, 0);
    xfer(0, 1, 32'h40, 32'h0BADF00D, 4'hF, 4'h1, 0, T_ERR, 0, 0, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'hF, 4'h0, 0,
         T_ACK, 32'hDEAD1234, 4'h2, 0);

    // Busy backing store: retry, then succeed.
    xfer(0, 0, 32'h00, 32'h0, 4'hF, 4'h0, 1, T_RTY, 0, 0, 0);
    xfer(0, 0, 32'h00, 32'h0, 4'hF, 4'h0, 0,
         T_ACK, 32'h0, 4'h0, 0);

    // Strobe held three cycles past ack, then a fresh request.
    xfer(0, 1, 32'h3C, 32'hCAFEF00D, 4'hF, 4'hA, 0, T_ACK, 0, 0, 3);
    xfer(0, 0, 32'h3C, 32'h0, 4'hF, 4'h0, 0,
         T_ACK, 32'hCAFEF00D, 4'hA, 0);

    // Three wait states: abandoned write leaves memory alone.
    xfer(1, 1, 32'h10, 32'h11223344, 4'hF, 4'h1, 0, T_ACK, 0, 0, 0);
    abort_wr(1, 32'h10, 32'h55667788, 0);
    xfer(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 0,
         T_ACK, 32'h11223344, 4'h1, 0);

    // Reset while waiting clears outputs and both memories.
    abort_wr(1, 32'h14, 32'h99AABBCC, 1);
    xfer(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 0, T_ACK, 32'h0, 4'h0, 0);
    xfer(1, 0, 32'h14, 32'h0, 4'hF, 4'h0, 0, T_ACK, 32'h0, 4'h0, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'hF, 4'h0, 0, T_ACK, 32'h0, 4'h0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending0", q[0].size(), 0);
    chk("pending1", q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
